ysyx_25040101_pc_seq: RTL and testbench



---
 rtl/ysyx_25040101_pc_pkg.sv | 17 +
 rtl/ysyx_25040101_pc_target.sv | 24 ++
 rtl/ysyx_25040101_pc_seq.sv | 143 ++++++++++++++
 tb/tb_ysyx_25040101_pc_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040101_pc_pkg.sv
// Shared types and defaults for the fetch-side PC sequencer.
package ysyx_25040101_pc_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t       RESET_PC_DEFAULT   = 32'h8000_0000;
    localparam int unsigned INST_BYTES_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_25040101_pc_target.sv
// Redirect target: srca + srcb with optional JALR bit-0 clear and misalign flag.
// Misalign detection only when YSYX_25040101_PC_MISALIGN_CHECK_EN is defined.
module ysyx_25040101_pc_target
    import ysyx_25040101_pc_pkg::*;
(
    input  addr_t srca,
    input  addr_t srcb,
    input  logic  jalr,
    output addr_t target_c,
    output logic  misalign_c
);

    always_comb begin
        target_c   = srca + srcb;
        misalign_c = 1'b0;
        if (jalr) begin
            target_c[0] = 1'b0;
        end
`ifdef YSYX_25040101_PC_MISALIGN_CHECK_EN
        misalign_c = target_c[1];
`endif
    end

endmodule

// File: rtl/ysyx_25040101_pc_seq.sv
// Fetch-side PC sequencer: owns the PC, issues IFU requests, flushes wrong-path responses.
// Optional target alignment check under YSYX_25040101_PC_MISALIGN_CHECK_EN.
module ysyx_25040101_pc_seq
    import ysyx_25040101_pc_pkg::*;
#(
    parameter addr_t       RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned INST_BYTES = INST_BYTES_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_srca_i,
    input  logic [31:0] redir_srcb_i,
    input  logic        redir_jalr_i,
    input  logic        trap_valid_i,
    input  logic [31:0] trap_pc_i,
    input  logic        stall_i,
    output logic        ifu_req_valid_o,
    output logic [31:0] ifu_req_pc_o,
    input  logic        ifu_req_ready_i,
    input  logic        ifu_rsp_valid_i,
    output logic        inst_valid_o,
    output logic        flush_o,
    output logic [31:0] pc_o,
    output logic        misalign_o
);

    state_e state, state_nx;
    addr_t  pc, pc_nx;
    addr_t  pend_pc, pend_pc_nx;
    logic   pend_valid, pend_valid_nx;
    logic   pend_is_trap, pend_is_trap_nx;
    logic   req_valid, req_valid_nx;
    logic   inst_valid, inst_valid_nx;
    logic   flush, flush_nx;
    logic   misalign, misalign_nx;
    logic   redir_take;
    addr_t  tgt_c;
    logic   tgt_misalign_c;

    ysyx_25040101_pc_target u_target (
        .srca       (redir_srca_i),
        .srcb       (redir_srcb_i),
        .jalr       (redir_jalr_i),
        .target_c   (tgt_c),
        .misalign_c (tgt_misalign_c)
    );

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= S_BOOT;
            pc           <= RESET_PC;
            pend_pc      <= RESET_PC;
            pend_valid   <= 1'b0;
            pend_is_trap <= 1'b0;
            req_valid    <= 1'b0;
            inst_valid   <= 1'b0;
            flush        <= 1'b0;
            misalign     <= 1'b0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            pend_pc      <= pend_pc_nx;
            pend_valid   <= pend_valid_nx;
            pend_is_trap <= pend_is_trap_nx;
            req_valid    <= req_valid_nx;
            inst_valid   <= inst_valid_nx;
            flush        <= flush_nx;
            misalign     <= misalign_nx;
        end
    end

    // Event capture (trap beats redirect; a pending trap blocks redirects), then FSM
    always_comb begin
        state_nx        = state;
        pc_nx           = pc;
        pend_pc_nx      = pend_pc;
        pend_valid_nx   = pend_valid;
        pend_is_trap_nx = pend_is_trap;
        inst_valid_nx   = 1'b0;
        flush_nx        = 1'b0;
        misalign_nx     = 1'b0;
        redir_take      = redir_valid_i && !trap_valid_i && !(pend_valid && pend_is_trap);

        if (trap_valid_i) begin
            pend_valid_nx   = 1'b1;
            pend_pc_nx      = trap_pc_i;
            pend_is_trap_nx = 1'b1;
        end else if (redir_take) begin
            if (tgt_misalign_c) begin
                misalign_nx = 1'b1;
            end else begin
                pend_valid_nx   = 1'b1;
                pend_pc_nx      = tgt_c;
                pend_is_trap_nx = 1'b0;
            end
        end

        case (state)
            S_BOOT: begin
                state_nx = S_REQ;
                if (pend_valid_nx) begin
                    pc_nx           = pend_pc_nx;
                    pend_valid_nx   = 1'b0;
                    pend_is_trap_nx = 1'b0;
                end
            end
            S_REQ: begin
                if (ifu_req_ready_i) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ifu_rsp_valid_i && !stall_i) begin
                    state_nx = S_REQ;
                    if (pend_valid_nx) begin
                        flush_nx        = 1'b1;
                        pc_nx           = pend_pc_nx;
                        pend_valid_nx   = 1'b0;
                        pend_is_trap_nx = 1'b0;
                    end else begin
                        inst_valid_nx = 1'b1;
                        pc_nx         = pc + addr_t'(INST_BYTES);
                    end
                end
            end
            default: begin
                state_nx = S_BOOT;
            end
        endcase

        req_valid_nx = (state_nx == S_REQ);
    end

    assign ifu_req_valid_o = req_valid;
    assign ifu_req_pc_o    = pc;
    assign pc_o            = pc;
    assign inst_valid_o    = inst_valid;
    assign flush_o         = flush;
    assign misalign_o      = misalign;

endmodule

// File: tb/tb_ysyx_25040101_pc_seq.sv
// Scoreboard bench for ysyx_25040101_pc_seq; exercises YSYX_25040101_PC_MISALIGN_CHECK_EN when defined.
module tb_ysyx_25040101_pc_seq;
    import ysyx_25040101_pc_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        redir_valid_i;
    logic [31:0] redir_srca_i;
    logic [31:0] redir_srcb_i;
    logic        redir_jalr_i;
    logic        trap_valid_i;
    logic [31:0] trap_pc_i;
    logic        stall_i;
    logic        ifu_req_valid_o;
    logic [31:0] ifu_req_pc_o;
    logic        ifu_req_ready_i;
    logic        ifu_rsp_valid_i;
    logic        inst_valid_o;
    logic        flush_o;
    logic [31:0] pc_o;
    logic        misalign_o;

    int errors = 0;
    int checks = 0;

    addr_t exp_req_q[$];
    bit    exp_flush_q[$];

    bit    ev_redir, ev_trap, ev_jalr, ev_redir2, ev_at_hold, ev_mis_exp;
    addr_t ev_srca, ev_srcb, ev_tpc, ev2_srca, ev2_srcb;

    always #5 clk_i = ~clk_i;

    ysyx_25040101_pc_seq dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .redir_valid_i   (redir_valid_i),
        .redir_srca_i    (redir_srca_i),
        .redir_srcb_i    (redir_srcb_i),
        .redir_jalr_i    (redir_jalr_i),
        .trap_valid_i    (trap_valid_i),
        .trap_pc_i       (trap_pc_i),
        .stall_i         (stall_i),
        .ifu_req_valid_o (ifu_req_valid_o),
        .ifu_req_pc_o    (ifu_req_pc_o),
        .ifu_req_ready_i (ifu_req_ready_i),
        .ifu_rsp_valid_i (ifu_rsp_valid_i),
        .inst_valid_o    (inst_valid_o),
        .flush_o         (flush_o),
        .pc_o            (pc_o),
        .misalign_o      (misalign_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic clear_ev();
        ev_redir = 1'b0; ev_trap = 1'b0; ev_jalr = 1'b0; ev_redir2 = 1'b0;
        ev_at_hold = 1'b0; ev_mis_exp = 1'b0;
        ev_srca = '0; ev_srcb = '0; ev_tpc = '0; ev2_srca = '0; ev2_srcb = '0;
    endtask

    task automatic apply_ev();
        redir_valid_i = ev_redir;
        redir_srca_i  = ev_srca;
        redir_srcb_i  = ev_srcb;
        redir_jalr_i  = ev_jalr;
        trap_valid_i  = ev_trap;
        trap_pc_i     = ev_tpc;
    endtask

    task automatic idle_ev();
        redir_valid_i = 1'b0;
        trap_valid_i  = 1'b0;
        redir_jalr_i  = 1'b0;
    endtask

    // One full fetch: request check, optional ready hold, optional event, stall, consume check
    task automatic fetch(input int ready_dly, input int stall_cyc, input bit inj_wait);
        int    n;
        addr_t held;
        bit    f;
        n = 0;
        while (!ifu_req_valid_o && n < 20) begin
            tick();
            n++;
        end
        if (!ifu_req_valid_o) begin
            check("req_timeout", 32'(ifu_req_valid_o), 32'd1);
            return;
        end
        if (exp_req_q.size() == 0) check("req_sb_empty", 32'd1, 32'd0);
        else check("req_pc", ifu_req_pc_o, exp_req_q.pop_front());
        held = ifu_req_pc_o;
        for (int i = 0; i < ready_dly; i++) begin
            ifu_req_ready_i = 1'b0;
            if (i == 0 && ev_at_hold) apply_ev();
            tick();
            idle_ev();
            check("hold_valid", 32'(ifu_req_valid_o), 32'd1);
            check("hold_pc", ifu_req_pc_o, held);
        end
        ifu_req_ready_i = 1'b1;
        tick();
        ifu_req_ready_i = 1'b0;
        if (inj_wait) begin
            apply_ev();
            tick();
            idle_ev();
            check("misalign", 32'(misalign_o), 32'(ev_mis_exp));
            if (ev_redir2) begin
                redir_valid_i = 1'b1;
                redir_srca_i  = ev2_srca;
                redir_srcb_i  = ev2_srcb;
                tick();
                idle_ev();
            end
        end
        ifu_rsp_valid_i = 1'b1;
        for (int i = 0; i < stall_cyc; i++) begin
            stall_i = 1'b1;
            tick();
            check("stall_pc", pc_o, held);
            check("stall_inst", 32'(inst_valid_o), 32'd0);
        end
        stall_i = 1'b0;
        tick();
        ifu_rsp_valid_i = 1'b0;
        if (exp_flush_q.size() == 0) begin
            check("rsp_sb_empty", 32'd1, 32'd0);
        end else begin
            f = exp_flush_q.pop_front();
            check("rsp_inst_valid", 32'(inst_valid_o), 32'(!f));
            check("rsp_flush", 32'(flush_o), 32'(f));
        end
    endtask

    task automatic expect_fetch(input addr_t pc, input bit f);
        exp_req_q.push_back(pc);
        exp_flush_q.push_back(f);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n_i = 1'b0;
        redir_valid_i = 1'b0; redir_srca_i = '0; redir_srcb_i = '0; redir_jalr_i = 1'b0;
        trap_valid_i = 1'b0; trap_pc_i = '0; stall_i = 1'b0;
        ifu_req_ready_i = 1'b0; ifu_rsp_valid_i = 1'b0;
        clear_ev();
        repeat (3) tick();
        check("rst_pc", pc_o, 32'h8000_0000);
        check("rst_req_valid", 32'(ifu_req_valid_o), 32'd0);
        check("rst_inst", 32'(inst_valid_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        rst_n_i = 1'b1;

        // Sequential fetches
        expect_fetch(32'h8000_0000, 1'b0);
        expect_fetch(32'h8000_0004, 1'b0);
        expect_fetch(32'h8000_0008, 1'b0);
        repeat (3) fetch(0, 0, 1'b0);

        // Redirect while waiting, target wraps to 0x80000000
        expect_fetch(32'h8000_000C, 1'b1);
        expect_fetch(32'h8000_0000, 1'b0);
        clear_ev(); ev_redir = 1'b1; ev_srca = 32'h8000_0010; ev_srcb = 32'hFFFF_FFF0;
        fetch(0, 0, 1'b1);
        clear_ev();
        fetch(0, 0, 1'b0);

        // JALR clears bit 0
        expect_fetch(32'h8000_0004, 1'b1);
        expect_fetch(32'h8000_0104, 1'b0);
        clear_ev(); ev_redir = 1'b1; ev_jalr = 1'b1; ev_srca = 32'h8000_0101; ev_srcb = 32'h4;
        fetch(0, 0, 1'b1);
        clear_ev();
        fetch(0, 0, 1'b0);

        // Trap beats same-cycle redirect; later redirect ignored
        expect_fetch(32'h8000_0108, 1'b1);
        expect_fetch(32'h8000_1000, 1'b0);
        clear_ev(); ev_trap = 1'b1; ev_tpc = 32'h8000_1000;
        ev_redir = 1'b1; ev_srca = 32'h8000_0000; ev_srcb = 32'h20;
        ev_redir2 = 1'b1; ev2_srca = 32'h8000_2000; ev2_srcb = 32'h0;
        fetch(0, 0, 1'b1);
        clear_ev();
        fetch(0, 0, 1'b0);

        // Ready held low while a redirect arrives
        expect_fetch(32'h8000_1004, 1'b1);
        expect_fetch(32'h8000_0200, 1'b0);
        clear_ev(); ev_at_hold = 1'b1; ev_redir = 1'b1; ev_srca = 32'h8000_0100; ev_srcb = 32'h100;
        fetch(5, 0, 1'b0);
        clear_ev();
        fetch(0, 0, 1'b0);

        // Stall holds the response
        expect_fetch(32'h8000_0204, 1'b0);
        fetch(0, 3, 1'b0);

        // Reset during S_WAIT; stale response afterwards ignored
        check("pre_rst_valid", 32'(ifu_req_valid_o), 32'd1);
        check("pre_rst_pc", ifu_req_pc_o, 32'h8000_0208);
        ifu_req_ready_i = 1'b1;
        tick();
        ifu_req_ready_i = 1'b0;
        ifu_rsp_valid_i = 1'b1;
        stall_i = 1'b1;
        tick();
        #2 rst_n_i = 1'b0;
        tick();
        check("mid_rst_pc", pc_o, 32'h8000_0000);
        check("mid_rst_valid", 32'(ifu_req_valid_o), 32'd0);
        stall_i = 1'b0;
        rst_n_i = 1'b1;
        tick();
        check("post_rst_inst", 32'(inst_valid_o), 32'd0);
        check("post_rst_flush", 32'(flush_o), 32'd0);
        ifu_rsp_valid_i = 1'b0;
        expect_fetch(32'h8000_0000, 1'b0);
        fetch(0, 0, 1'b0);

`ifdef YSYX_25040101_PC_MISALIGN_CHECK_EN
        // Misaligned redirect target is flagged and dropped
        expect_fetch(32'h8000_0004, 1'b0);
        expect_fetch(32'h8000_0008, 1'b0);
        clear_ev(); ev_redir = 1'b1; ev_srca = 32'h8000_0100; ev_srcb = 32'h2; ev_mis_exp = 1'b1;
        fetch(0, 0, 1'b1);
        clear_ev();
        fetch(0, 0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
